// File: rtl/mmio_initiator_pkg.sv
// Shared frontend definitions for the MMIO initiator and its responder.
// Holds the bus field widths, the request record latched for the bus phase,
// the initiator FSM state type and a small alignment helper.
package mmio_initiator_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;

    // Request fields latched on acceptance and presented to the responder.
    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] wdata;
        logic             rw;     // 1 = write, 0 = read
    } mmio_req_t;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } mmio_state_e;

    // Only word-aligned accesses reach the bus.
    function automatic logic addr_misaligned(input logic [AddrW-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mmio_initiator.sv
// MMIO initiator: accepts one core request at a time, runs a single bus
// transaction against an MMIO responder and returns one response.
// Misaligned requests are answered with an error without touching the bus;
// a responder that never completes is aborted after TIMEOUT bus cycles.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        core request handshake
//   req_addr/wdata/rw          core request fields
//   resp_valid/resp_ready      core response handshake
//   resp_data/resp_err         response payload
//   mmio_valid/mmio_ready      bus request / completion strobe
//   mmio_addr/dtw/rw           bus request fields (zero outside the bus phase)
//   mmio_dtr                   bus read data, sampled only with mmio_ready
module mmio_initiator
    import mmio_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AddrW-1:0] req_addr,
    input  logic [DataW-1:0] req_wdata,
    input  logic             req_rw,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DataW-1:0] resp_data,
    output logic             resp_err,

    output logic             mmio_valid,
    input  logic             mmio_ready,
    output logic [AddrW-1:0] mmio_addr,
    output logic [DataW-1:0] mmio_dtw,
    input  logic [DataW-1:0] mmio_dtr,
    output logic             mmio_rw
);

    localparam int unsigned CntLog = $clog2(TIMEOUT + 1);
    localparam int unsigned CntW   = (CntLog > 8) ? CntLog : 8;

    mmio_state_e      state_q, state_d;
    mmio_req_t        req_q, req_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  cnt_inc;
    logic [DataW-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        // Saturating increment: the counter never wraps back below TIMEOUT.
        cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (addr_misaligned(req_addr)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        req_d.addr  = req_addr;
                        req_d.wdata = req_wdata;
                        req_d.rw    = req_rw;
                        cnt_d       = '0;
                        state_d     = StBus;
                    end
                end
            end
            StBus: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (mmio_ready) begin
                    rdata_d = req_q.rw ? '0 : mmio_dtr;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_inc;
                    if (TIMEOUT != 0 && 32'(cnt_inc) >= TIMEOUT) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from the state register so reset clears them at once.
    always_comb begin
        req_ready  = (state_q == StIdle) && !reset;
        mmio_valid = (state_q == StBus);
        mmio_addr  = mmio_valid ? req_q.addr  : '0;
        mmio_dtw   = mmio_valid ? req_q.wdata : '0;
        mmio_rw    = mmio_valid ? req_q.rw    : 1'b0;
        resp_valid = (state_q == StResp);
        resp_data  = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid & err_q;
    end

endmodule

// File: tb/tb_mmio_initiator.sv
// Self-checking bench for mmio_initiator built with a short timeout so both
// the abort path and the ready-on-last-cycle corner are reachable quickly.
module tb_mmio_initiator;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_rw = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mmio_valid;
    logic        mmio_ready = 1'b0;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_dtw;
    logic [31:0] mmio_dtr = '0;
    logic        mmio_rw;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mmio_initiator #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rw     (req_rw),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mmio_valid (mmio_valid),
        .mmio_ready (mmio_ready),
        .mmio_addr  (mmio_addr),
        .mmio_dtw   (mmio_dtw),
        .mmio_dtr   (mmio_dtr),
        .mmio_rw    (mmio_rw)
    );

    // Reference: what a transaction must produce, from the block's rules.
    // ready_at = bus cycle (1-based) on which the responder completes, 0 = never.
    function automatic void model(input logic [31:0] addr, input logic rw,
                                  input logic [31:0] dtr, input int ready_at,
                                  output logic [31:0] data, output logic err,
                                  output int cycles);
        if (addr % 4 != 0) begin
            data = 0; err = 1'b1; cycles = 0;
        end else if (ready_at != 0 && ready_at <= int'(TO)) begin
            data = rw ? 32'd0 : dtr; err = 1'b0; cycles = ready_at;
        end else begin
            data = 0; err = 1'b1; cycles = int'(TO);
        end
    endfunction

    // Drives one transaction at negedges and reports what was seen.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic rw,
                           input logic [31:0] dtr, input int ready_at, input int hold,
                           output logic [31:0] got_data, output logic got_err,
                           output int bus_cycles, output bit fields_ok, output bit lat_ok,
                           output bit resp_ok, output bit idle_ok);
        bit got;
        got = 1'b0; bus_cycles = 0; fields_ok = 1'b1; lat_ok = 1'b1;
        resp_ok = 1'b1; idle_ok = 1'b1;
        got_data = 'x; got_err = 1'bx;
        @(negedge clk);
        if (req_ready !== 1'b1) idle_ok = 1'b0;
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_rw = rw;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rw = $urandom_range(0, 1);
        for (int i = 0; i < 32; i++) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (mmio_valid !== 1'b1) break;
            bus_cycles++;
            if (mmio_addr !== addr || mmio_dtw !== wdata || mmio_rw !== rw || req_ready !== 1'b0)
                fields_ok = 1'b0;
            mmio_ready = (bus_cycles == ready_at);
            mmio_dtr   = mmio_ready ? dtr : $urandom;
            @(negedge clk);
            if (mmio_ready && resp_valid !== 1'b1) lat_ok = 1'b0;
            mmio_ready = 1'b0;
        end
        if (!got) begin
            resp_ok = 1'b0;
            idle_ok = 1'b0;
            return;
        end
        got_data = resp_data;
        got_err  = resp_err;
        if (mmio_valid !== 1'b0 || mmio_addr !== 0 || mmio_dtw !== 0 || req_ready !== 1'b0)
            resp_ok = 1'b0;
        for (int i = 0; i < hold; i++) begin
            // Completion strobes and read data outside the bus phase must be ignored.
            mmio_ready = 1'($urandom_range(0, 1));
            mmio_dtr   = $urandom;
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== got_data || resp_err !== got_err ||
                req_ready !== 1'b0 || mmio_valid !== 1'b0)
                resp_ok = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        mmio_ready = 1'b0;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mmio_valid !== 1'b0) idle_ok = 1'b0;
    endtask

    task automatic test_reset();
        #23 reset = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        tests++;
        if ({resp_valid, resp_err, mmio_valid, mmio_rw} !== 4'b0 || resp_data !== 0 ||
            mmio_addr !== 0 || mmio_dtw !== 0) begin
            fails++;
            $display("FAIL reset_outputs got rv=%b re=%b rd=%h mv=%b ma=%h md=%h want all 0",
                     resp_valid, resp_err, resp_data, mmio_valid, mmio_addr, mmio_dtw);
        end
    endtask

    task automatic test_read();
        logic [31:0] d; logic e; int c; bit f, l, r, i;
        run_txn(32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 0, d, e, c, f, l, r, i);
        tests++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            fails++; $display("FAIL read_resp got %h/%b want deadbeef/0", d, e);
        end
        tests++;
        if (c != 3 || !l || !f) begin
            fails++; $display("FAIL read_bus got cycles=%0d lat=%b fields=%b want 3/1/1", c, l, f);
        end
    endtask

    task automatic test_write();
        logic [31:0] d; logic e; int c; bit f, l, r, i;
        run_txn(32'h20, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1, 0, d, e, c, f, l, r, i);
        tests++;
        if (d !== 32'h0 || e !== 1'b0) begin
            fails++; $display("FAIL write_resp got %h/%b want 0/0", d, e);
        end
        tests++;
        if (c != 1 || !f || !l || !i) begin
            fails++;
            $display("FAIL write_bus got cycles=%0d fields=%b lat=%b idle=%b want 1/1/1/1",
                     c, f, l, i);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] d; logic e; int c; bit f, l, r, i;
        run_txn(32'h13, 32'h5, 1'b1, 32'h0, 1, 0, d, e, c, f, l, r, i);
        tests++;
        if (c != 0 || d !== 32'h0 || e !== 1'b1) begin
            fails++; $display("FAIL misaligned got cycles=%0d %h/%b want 0 0/1", c, d, e);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic e; int c; bit f, l, r, i;
        run_txn(32'h40, 32'h0, 1'b0, 32'hCAFEF00D, 0, 0, d, e, c, f, l, r, i);
        tests++;
        if (c != int'(TO) || d !== 32'h0 || e !== 1'b1) begin
            fails++; $display("FAIL timeout_abort got cycles=%0d %h/%b want %0d 0/1", c, d, e, TO);
        end
        run_txn(32'h44, 32'h0, 1'b0, 32'hCAFEF00D, int'(TO), 0, d, e, c, f, l, r, i);
        tests++;
        if (c != int'(TO) || d !== 32'hCAFEF00D || e !== 1'b0) begin
            fails++;
            $display("FAIL timeout_ready_wins got cycles=%0d %h/%b want %0d cafef00d/0",
                     c, d, e, TO);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e; int c; bit f, l, r, i;
        run_txn(32'h80, 32'h0, 1'b0, 32'h0BADF00D, 2, 5, d, e, c, f, l, r, i);
        tests++;
        if (d !== 32'h0BADF00D || e !== 1'b0 || !r || !i) begin
            fails++;
            $display("FAIL backpressure got %h/%b stable=%b idle=%b want 0badf00d/0/1/1",
                     d, e, r, i);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, w, t, d, xd; logic rw, e, xe; int ra, h, c, xc; bit f, l, r, i;
        for (int n = 0; n < 24; n++) begin
            a  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            w  = $urandom;
            t  = $urandom;
            rw = 1'($urandom_range(0, 1));
            ra = $urandom_range(0, 6);
            h  = $urandom_range(0, 3);
            model(a, rw, t, ra, xd, xe, xc);
            run_txn(a, w, rw, t, ra, h, d, e, c, f, l, r, i);
            tests++;
            if (d !== xd || e !== xe) begin
                fails++; $display("FAIL rand%0d_resp got %h/%b want %h/%b", n, d, e, xd, xe);
            end
            tests++;
            if (c != xc || !f || !l || !r || !i) begin
                fails++;
                $display("FAIL rand%0d_proto got cycles=%0d f=%b l=%b r=%b i=%b want %0d/1/1/1/1",
                         n, c, f, l, r, i, xc);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Mid-bus
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h100; req_wdata = 32'hA5A5A5A5; req_rw = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (mmio_valid !== 1'b1) begin
            fails++; $display("FAIL rst_bus_pre got mmio_valid=%b want 1", mmio_valid);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (mmio_valid !== 1'b0 || mmio_addr !== 0 || mmio_dtw !== 0 || mmio_rw !== 1'b0 ||
            resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_bus_async got mv=%b ma=%h md=%h rv=%b want 0", mmio_valid,
                     mmio_addr, mmio_dtw, resp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL rst_bus_after got rr=%b rv=%b want 1/0", req_ready, resp_valid);
        end
        // Mid-response
        req_valid = 1'b1; req_addr = 32'h101;
        @(negedge clk);
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        tests++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_data !== 0) begin
            fails++;
            $display("FAIL rst_resp_async got rv=%b re=%b rd=%h want 0", resp_valid, resp_err,
                     resp_data);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL rst_resp_after got rr=%b rv=%b want 1/0", req_ready, resp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_misaligned();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
